imm_multicycle_ctrl: RTL and testbench

IMM_MULTICYCLE_CTRL -- requirements
Module: imm_multicycle_ctrl

---
 rtl/imm_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_imm_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences datapath strobes, decodes ALU op and immediate type.
// Optional feature: define RV32_UTYPE_EN to support lui/auipc through the UTYPE state.
module imm_multicycle_ctrl #(
    parameter bit ILLEGAL_STICKY = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [2:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_UTYPE    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [2:0] alu_dec_c;
    logic       adrsrc_c, irwrite_c, pcwrite_c, regwrite_c, memwrite_c;

    // State and illegal flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        immsrc = 3'b000;
        case (op)
            OP_STORE: immsrc = 3'b001;
            OP_BR:    immsrc = 3'b010;
            OP_JAL:   immsrc = 3'b100;
`ifdef RV32_UTYPE_EN
            OP_LUI, OP_AUIPC: immsrc = 3'b011;
`endif
            default:  immsrc = 3'b000;
        endcase
    end

    // funct3/funct7 ALU decode; sub only for R-type (op[5]) with funct7b5
    always_comb begin
        alu_dec_c = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec_c = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec_c = ALU_SLT;
            3'b110:  alu_dec_c = ALU_OR;
            3'b111:  alu_dec_c = ALU_AND;
            default: alu_dec_c = ALU_ADD;
        endcase
    end

    // Next-state and Moore outputs
    always_comb begin
        state_d    = S_FETCH;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        alucontrol = ALU_ADD;
        adrsrc_c   = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memwrite_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d   = S_DECODE;
                irwrite_c = 1'b1;
                pcwrite_c = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
`ifdef RV32_UTYPE_EN
                    OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
`endif
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                state_d  = S_MEMWB;
                adrsrc_c = 1'b1;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_c = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_c   = 1'b1;
                memwrite_c = 1'b1;
            end
            S_EXECR: begin
                state_d    = S_ALUWB;
                alusrca    = 2'b10;
                alucontrol = alu_dec_c;
            end
            S_EXECI: begin
                state_d    = S_ALUWB;
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                alucontrol = alu_dec_c;
            end
            S_ALUWB: regwrite_c = 1'b1;
            S_BRANCH: begin
                alusrca    = 2'b10;
                alucontrol = ALU_SUB;
                pcwrite_c  = zero ^ funct3[0];
            end
            S_JAL: begin
                state_d   = S_ALUWB;
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                pcwrite_c = 1'b1;
            end
            S_UTYPE: begin
                state_d = S_ALUWB;
                alusrca = op[5] ? 2'b11 : 2'b01;
                alusrcb = 2'b01;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // An unsupported opcode is the only way DECODE falls back to FETCH
    always_comb begin
        illegal_d = (state_q == S_DECODE) && (state_d == S_FETCH);
        if (ILLEGAL_STICKY && illegal_q) begin
            illegal_d = 1'b1;
        end
    end

    // Strobes held off while reset is asserted
    assign adrsrc   = adrsrc_c   & ~reset;
    assign irwrite  = irwrite_c  & ~reset;
    assign pcwrite  = pcwrite_c  & ~reset;
    assign regwrite = regwrite_c & ~reset;
    assign memwrite = memwrite_c & ~reset;
    assign state    = state_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_imm_multicycle_ctrl.sv
// Table-driven bench for imm_multicycle_ctrl, plus hand-written reset and sticky-illegal sequences.
module tb_imm_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] r;
        logic [4:0] stb;  // {adrsrc, irwrite, pcwrite, regwrite, memwrite}
        logic [2:0] alu;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        outs_t      exp;
    } vec_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] BAD = 7'b0000000;

    logic       clk, reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic [2:0] immsrc, alucontrol, s_immsrc, s_alucontrol;
    logic [1:0] alusrca, alusrcb, resultsrc, s_alusrca, s_alusrcb, s_resultsrc;
    logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal;
    logic       s_adrsrc, s_irwrite, s_pcwrite, s_regwrite, s_memwrite, s_illegal;
    logic [3:0] state, s_state;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    imm_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
        .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
        .memwrite(memwrite), .alucontrol(alucontrol), .state(state), .illegal(illegal)
    );

    imm_multicycle_ctrl #(.ILLEGAL_STICKY(1'b1)) dut_s (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .immsrc(s_immsrc), .alusrca(s_alusrca), .alusrcb(s_alusrcb), .resultsrc(s_resultsrc),
        .adrsrc(s_adrsrc), .irwrite(s_irwrite), .pcwrite(s_pcwrite), .regwrite(s_regwrite),
        .memwrite(s_memwrite), .alucontrol(s_alucontrol), .state(s_state), .illegal(s_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input logic [3:0] st, input logic [2:0] imm, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] r, input logic [4:0] stb,
                       input logic [2:0] alu, input logic ill);
        vec_t v;
        v.op  = o;
        v.f3  = f3;
        v.f7  = f7;
        v.z   = z;
        v.exp = '{st, imm, a, b, r, stb, alu, ill};
        vq.push_back(v);
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3);
        op       = o;
        funct3   = f3;
        funct7b5 = 1'b0;
        zero     = 1'b0;
    endtask

    outs_t act;
    logic  sticky_exp;

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        drive(LW, 3'b010);

        // lw: 0,1,2,3,4
        add(LW, 3'b010, 0, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(LW, 3'b010, 0, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(LW, 3'b010, 0, 0, 4'd2, 3'b000, 2'b10, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(LW, 3'b010, 0, 0, 4'd3, 3'b000, 2'b00, 2'b00, 2'b00, 5'b10000, 3'b000, 0);
        add(LW, 3'b010, 0, 0, 4'd4, 3'b000, 2'b00, 2'b00, 2'b01, 5'b00010, 3'b000, 0);
        // sw: 0,1,2,5
        add(SW, 3'b010, 0, 0, 4'd0, 3'b001, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(SW, 3'b010, 0, 0, 4'd1, 3'b001, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(SW, 3'b010, 0, 0, 4'd2, 3'b001, 2'b10, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(SW, 3'b010, 0, 0, 4'd5, 3'b001, 2'b00, 2'b00, 2'b00, 5'b10001, 3'b000, 0);
        // R-type sub
        add(RT, 3'b000, 1, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(RT, 3'b000, 1, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(RT, 3'b000, 1, 0, 4'd6, 3'b000, 2'b10, 2'b00, 2'b00, 5'b00000, 3'b001, 0);
        add(RT, 3'b000, 1, 0, 4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00010, 3'b000, 0);
        // R-type and (zero high must not matter) and or
        add(RT, 3'b111, 0, 1, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(RT, 3'b111, 0, 1, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(RT, 3'b111, 0, 1, 4'd6, 3'b000, 2'b10, 2'b00, 2'b00, 5'b00000, 3'b010, 0);
        add(RT, 3'b111, 0, 1, 4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00010, 3'b000, 0);
        add(RT, 3'b110, 0, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(RT, 3'b110, 0, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(RT, 3'b110, 0, 0, 4'd6, 3'b000, 2'b10, 2'b00, 2'b00, 5'b00000, 3'b011, 0);
        add(RT, 3'b110, 0, 0, 4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00010, 3'b000, 0);
        // addi with funct7b5=1 stays add; slti
        add(IT, 3'b000, 1, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(IT, 3'b000, 1, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(IT, 3'b000, 1, 0, 4'd7, 3'b000, 2'b10, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(IT, 3'b000, 1, 0, 4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00010, 3'b000, 0);
        add(IT, 3'b010, 0, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(IT, 3'b010, 0, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(IT, 3'b010, 0, 0, 4'd7, 3'b000, 2'b10, 2'b01, 2'b00, 5'b00000, 3'b101, 0);
        add(IT, 3'b010, 0, 0, 4'd8, 3'b000, 2'b00, 2'b00, 2'b00, 5'b00010, 3'b000, 0);
        // beq zero=1 taken; bne zero=1 not taken; bne zero=0 taken
        add(BR, 3'b000, 0, 1, 4'd0, 3'b010, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(BR, 3'b000, 0, 1, 4'd1, 3'b010, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(BR, 3'b000, 0, 1, 4'd9, 3'b010, 2'b10, 2'b00, 2'b00, 5'b00100, 3'b001, 0);
        add(BR, 3'b001, 0, 1, 4'd0, 3'b010, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(BR, 3'b001, 0, 1, 4'd1, 3'b010, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(BR, 3'b001, 0, 1, 4'd9, 3'b010, 2'b10, 2'b00, 2'b00, 5'b00000, 3'b001, 0);
        add(BR, 3'b001, 0, 0, 4'd0, 3'b010, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(BR, 3'b001, 0, 0, 4'd1, 3'b010, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(BR, 3'b001, 0, 0, 4'd9, 3'b010, 2'b10, 2'b00, 2'b00, 5'b00100, 3'b001, 0);
        // jal: 0,1,10,8
        add(JL, 3'b000, 0, 0, 4'd0, 3'b100, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(JL, 3'b000, 0, 0, 4'd1, 3'b100, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(JL, 3'b000, 0, 0, 4'd10, 3'b100, 2'b01, 2'b10, 2'b00, 5'b00100, 3'b000, 0);
        add(JL, 3'b000, 0, 0, 4'd8, 3'b100, 2'b00, 2'b00, 2'b00, 5'b00010, 3'b000, 0);
`ifdef RV32_UTYPE_EN
        // lui: 0,1,11,8
        add(LUI, 3'b000, 0, 0, 4'd0, 3'b011, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(LUI, 3'b000, 0, 0, 4'd1, 3'b011, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(LUI, 3'b000, 0, 0, 4'd11, 3'b011, 2'b11, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(LUI, 3'b000, 0, 0, 4'd8, 3'b011, 2'b00, 2'b00, 2'b00, 5'b00010, 3'b000, 0);
        add(BAD, 3'b000, 0, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
`else
        // lui unsupported: 0,1 then illegal pulse in next FETCH
        add(LUI, 3'b000, 0, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 0);
        add(LUI, 3'b000, 0, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(BAD, 3'b000, 0, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 1);
`endif
        add(BAD, 3'b000, 0, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        // lw after an illegal op: pulse seen in its FETCH only
        add(LW, 3'b010, 0, 0, 4'd0, 3'b000, 2'b00, 2'b10, 2'b10, 5'b01100, 3'b000, 1);
        add(LW, 3'b010, 0, 0, 4'd1, 3'b000, 2'b01, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(LW, 3'b010, 0, 0, 4'd2, 3'b000, 2'b10, 2'b01, 2'b00, 5'b00000, 3'b000, 0);
        add(LW, 3'b010, 0, 0, 4'd3, 3'b000, 2'b00, 2'b00, 2'b00, 5'b10000, 3'b000, 0);
        add(LW, 3'b010, 0, 0, 4'd4, 3'b000, 2'b00, 2'b00, 2'b01, 5'b00010, 3'b000, 0);

        // Reset state: FETCH, no strobes while reset held
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_irwrite", 32'(irwrite), 32'd0);
        chk("rst_pcwrite", 32'(pcwrite), 32'd0);
        chk("rst_memwrite", 32'(memwrite), 32'd0);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        sticky_exp = 1'b0;
        foreach (vq[i]) begin
            op       = vq[i].op;
            funct3   = vq[i].f3;
            funct7b5 = vq[i].f7;
            zero     = vq[i].z;
            #1;
            act = {state, immsrc, alusrca, alusrcb, resultsrc,
                   adrsrc, irwrite, pcwrite, regwrite, memwrite, alucontrol, illegal};
            chk($sformatf("vec%0d_outs", i), 32'(act), 32'(vq[i].exp));
            sticky_exp = sticky_exp | vq[i].exp.ill;
            chk($sformatf("vec%0d_sticky_illegal", i), 32'(s_illegal), 32'(sticky_exp));
            chk($sformatf("vec%0d_sticky_state", i), 32'(s_state), 32'(vq[i].exp.st));
            @(negedge clk);
        end

        // Async reset while in MEMWRITE
        drive(SW, 3'b010);
        #1 chk("sw_st0", 32'(state), 32'd0);
        @(negedge clk);
        #1 chk("sw_st1", 32'(state), 32'd1);
        @(negedge clk);
        #1 chk("sw_st2", 32'(state), 32'd2);
        @(negedge clk);
        #1;
        chk("sw_st5", 32'(state), 32'd5);
        chk("sw_memwrite", 32'(memwrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_memwrite", 32'(memwrite), 32'd0);
        chk("async_irwrite", 32'(irwrite), 32'd0);
        chk("async_sticky_clr", 32'(s_illegal), 32'd0);
        chk("async_sticky_state", 32'(s_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_irwrite", 32'(irwrite), 32'd1);
        chk("post_rst_pcwrite", 32'(pcwrite), 32'd1);
        @(negedge clk);
        #1 chk("post_rst_decode", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
